get_arbiter: RTL

- Registered N-way arbiter that shares one downstream resource between NumReq requesters. The resource is a single consumer with a ready input.
- Grant policy is chosen at elaboration by an enum parameter. Generate branches select the policy, using a set-membership test with a default fallback branch.
- Sits between requester ports and the shared resource. It issues one grant at a time and holds it until the resource completes a valid/ready handshake.

---
 rtl/arb_pkg.sv | 6 +
 rtl/arb_rr_pick.sv | 28 ++
 rtl/get_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared policy/state types and limits for get_arbiter
package arb_pkg;
   typedef enum int {ArbFixed = 0, ArbRoundRobin = 1, ArbLocked = 2, ArbDefault = 100} arb_policy_e;
   typedef enum logic [1:0] {Idle, Grant, Hold} arb_state_e;
   localparam int MaxNumReq = 16;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: picks the first set request at or after ptr (wrapping); ptr=0 gives fixed priority
module arb_rr_pick #(
   parameter int N = 4,
   parameter int IdW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IdW-1:0] ptr,
   output logic [N-1:0]   win,
   output logic [IdW-1:0] idx
);
   logic [IdW:0] j;
   logic found;
   always_comb begin
      win = '0;
      idx = '0;
      found = 1'b0;
      j = '0;
      for (int i = 0; i < N; i++) begin
         j = {1'b0, ptr} + (IdW+1)'(i);
         j = (j >= (IdW+1)'(N)) ? j - (IdW+1)'(N) : j;
         if (!found && req[j[IdW-1:0]]) begin
            found = 1'b1;
            win[j[IdW-1:0]] = 1'b1;
            idx = j[IdW-1:0];
         end
      end
   end
endmodule

// File: rtl/get_arbiter.sv
// get_arbiter: registered N-way arbiter, one grant held until a valid/ready handshake.
// Define GET_ARB_STATS_EN to add grant_count, a saturating count of completed handshakes.
module get_arbiter
   import arb_pkg::*;
#(
   parameter int          NumReq = 4,
   parameter arb_policy_e Policy = ArbRoundRobin,
   parameter int          IdW    = $clog2(NumReq)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NumReq-1:0] req,
   input  logic              res_ready,
   output logic [NumReq-1:0] gnt,
   output logic              gnt_valid,
   output logic [IdW-1:0]    gnt_id,
   output logic              busy
`ifdef GET_ARB_STATS_EN
   ,
   output logic [15:0]       grant_count
`endif
);
   arb_state_e state, state_n;
   logic [IdW-1:0] ptr, pick_ptr, win_id;
   logic [NumReq-1:0] req_m, win;
   logic lock_en, pol_ok, hs, lock_hit, stay;
   if (NumReq < 2 || NumReq > MaxNumReq) begin : g_bad_n
      $error("get_arbiter: NumReq %0d outside 2..%0d", NumReq, MaxNumReq);
   end
   if (Policy inside {ArbRoundRobin, ArbDefault}) begin : g_rr
      assign pick_ptr = ptr;
      assign lock_en  = 1'b0;
      assign pol_ok   = 1'b1;
   end else if (Policy == ArbFixed) begin : g_fixed
      assign pick_ptr = '0;
      assign lock_en  = 1'b0;
      assign pol_ok   = 1'b1;
   end else if (Policy == ArbLocked) begin : g_locked
      assign pick_ptr = ptr;
      assign lock_en  = 1'b1;
      assign pol_ok   = 1'b1;
   end else begin : g_bad_policy
      $error("get_arbiter: unsupported Policy %0d", Policy);
      assign pick_ptr = '0;
      assign lock_en  = 1'b0;
      assign pol_ok   = 1'b0;
   end
   // An unsupported policy never sees a request, so it idles with all outputs at zero.
   assign req_m = pol_ok ? req : '0;
   arb_rr_pick #(.N(NumReq), .IdW(IdW)) u_pick (
      .req(req_m),
      .ptr(pick_ptr),
      .win(win),
      .idx(win_id)
   );
   assign hs       = gnt_valid && res_ready;
   assign lock_hit = lock_en && req[gnt_id];
   assign busy     = state != Idle;
   // stay: current grant is kept; otherwise the winner (or nothing) is loaded this edge.
   always_comb begin
      stay    = (state == Grant) ? (!hs || lock_hit) : (state == Hold && lock_hit);
      state_n = stay ? ((state == Grant && hs) ? Hold : state) : (|req_m ? Grant : Idle);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= Idle;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         ptr       <= '0;
      end else begin
         state <= state_n;
         if (!stay) begin
            gnt       <= win;
            gnt_id    <= win_id;
            gnt_valid <= |req_m;
            if (|req_m) ptr <= (win_id == IdW'(NumReq-1)) ? '0 : win_id + 1'b1;
         end
      end
   end
`ifdef GET_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) grant_count <= '0;
      else if (hs && grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
   end
`endif
endmodule
